// File: rtl/pe_output_packer.sv
// Writeback packer: snapshots PE outputs, truncates to layer precision and packs them LSB-first into 32-bit words.
// Optional PACKER_BYTE_MASK_EN adds a mem_be byte-enable output for partial final words.
module pe_output_packer #(
  parameter int NUM_PE         = 8,
  parameter int ACC_DATA_WIDTH = 32,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       PRECISION,
  input  logic                             capture,
  input  logic [NUM_PE*ACC_DATA_WIDTH-1:0] pe_out,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic                             clear_overrun,
  output logic                             mem_req,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]        mem_wdata,
  input  logic                             mem_gnt,
  output logic                             busy,
  output logic                             done,
`ifdef PACKER_BYTE_MASK_EN
  output logic [3:0]                       mem_be,
`endif
  output logic                             overrun
);

  // state | meaning
  // IDLE  | waiting for capture
  // PACK  | one element per cycle into the current slot
  // WRITE | mem_req high, word held until mem_gnt
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, PACK, WRITE, DONE} state_t;

  localparam int EW = $clog2(NUM_PE + 1);

  state_t                           state, state_nxt;
  logic [NUM_PE*ACC_DATA_WIDTH-1:0] snap_q;
  logic [1:0]                       prec_q;
  logic [ADDR_WIDTH-1:0]            addr_q;
  logic [EW-1:0]                    elem_q;
  logic [3:0]                       slot_q;
  logic [MEM_DATA_WIDTH-1:0]        word_q;
  logic                             overrun_q;

  logic [3:0]                       slot_last;
  logic [7:0]                       elem_raw;
  logic [7:0]                       elem_mask;
  logic [4:0]                       elem_sh;
  logic [MEM_DATA_WIDTH-1:0]        elem_word;
  logic                             last_elem;
  logic                             pack_to_write;
  logic                             all_packed;

  // Precision decode: slot_last = E-1, elem_sh = slot*w
  always_comb begin
    slot_last = 4'd7;
    elem_mask = 8'h0F;
    elem_sh   = {slot_q[2:0], 2'b00};
    case (prec_q)
      2'd0: begin
        slot_last = 4'd3;
        elem_mask = 8'hFF;
        elem_sh   = {slot_q[1:0], 3'b000};
      end
      2'd2: begin
        slot_last = 4'd15;
        elem_mask = 8'h03;
        elem_sh   = {slot_q, 1'b0};
      end
      default: begin
        slot_last = 4'd7;
        elem_mask = 8'h0F;
        elem_sh   = {slot_q[2:0], 2'b00};
      end
    endcase
    elem_raw      = 8'(snap_q >> (32'(elem_q) * ACC_DATA_WIDTH));
    elem_word     = MEM_DATA_WIDTH'(elem_raw & elem_mask) << elem_sh;
    last_elem     = (elem_q == EW'(NUM_PE - 1));
    pack_to_write = (slot_q == slot_last) || last_elem;
    all_packed    = (elem_q == EW'(NUM_PE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (capture) state_nxt = PACK;
      end
      PACK: begin
        if (pack_to_write) state_nxt = WRITE;
      end
      WRITE: begin
        mem_req = 1'b1;
        if (mem_gnt) state_nxt = all_packed ? DONE : PACK;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_q <= '0;
      prec_q <= '0;
      addr_q <= '0;
      elem_q <= '0;
      slot_q <= '0;
      word_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            snap_q <= pe_out;
            prec_q <= PRECISION;
            addr_q <= base_addr;
            elem_q <= '0;
            slot_q <= '0;
            word_q <= '0;
          end
        end
        PACK: begin
          word_q <= word_q | elem_word;
          elem_q <= elem_q + 1'b1;
          if (!pack_to_write) slot_q <= slot_q + 1'b1;
        end
        WRITE: begin
          if (mem_gnt) begin
            addr_q <= addr_q + 1'b1;
            word_q <= '0;
            slot_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // A rejected capture sets overrun even when clear_overrun is asserted alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          overrun_q <= 1'b0;
    else if (capture && state != IDLE)   overrun_q <= 1'b1;
    else if (clear_overrun)              overrun_q <= 1'b0;
  end

`ifdef PACKER_BYTE_MASK_EN
  logic [3:0] be_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      be_q <= '0;
    end else if (state == IDLE && capture) begin
      be_q <= '0;
    end else if (state == PACK) begin
      be_q <= be_q | (4'b0001 << elem_sh[4:3]);
    end else if (state == WRITE && mem_gnt) begin
      be_q <= '0;
    end
  end

  assign mem_be = be_q;
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/pe_output_packer.md
Name: pe_output_packer

Overview:
- Writeback end of the PE array. Captures the NUM_PE already-saturated PE outputs (`out` of each PE) in one snapshot.
- Truncates each output to the layer precision (8/4/2-bit) and packs the elements LSB-first into 32-bit activation-memory words.
- Issues one memory write per word over a req/gnt handshake, then pulses done.

Parameters:
- NUM_PE, 8, number of PE outputs captured per snapshot (≥1).
- ACC_DATA_WIDTH, 32, width of each PE output.
- MEM_DATA_WIDTH, 32, memory word width; fixed at 32.
- ADDR_WIDTH, 12, memory word-address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- PRECISION  in  2  0=8-bit, 1=4-bit, 2=2-bit, 3=4-bit; sampled on capture
- capture  in  1  snapshot request
- pe_out  in  NUM_PE*ACC_DATA_WIDTH  PE outputs; PE k at [k*32 +: 32]
- base_addr  in  ADDR_WIDTH  first word address; sampled on capture
- clear_overrun  in  1  clears overrun
- mem_req  out  1  write request
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  packed word
- mem_gnt  in  1  grant; the transfer completes in a cycle where mem_req=1 and mem_gnt=1
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at the end of a snapshot
- overrun  out  1  sticky: capture was asserted while not IDLE

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE.
  - mem_req, mem_addr, mem_wdata, busy, done, overrun and all internal registers go to 0.
  - This applies immediately, including mid-transfer; no partial word is completed afterwards.
- Element width w and elements per word E:
  - PRECISION 0: w=8, E=4.
  - PRECISION 1 or 3: w=4, E=8.
  - PRECISION 2: w=2, E=16.
- Element k = pe_out[k*32 +: w]. This is plain truncation; saturation is already done in the PE.
- Slot s of a word occupies mem_wdata[s*w +: w]. Unused slots of the final partial word are 0.
- Word count = ceil(NUM_PE/E). Word n is written to base_addr+n; the address wraps modulo 2^ADDR_WIDTH.
- FSM states: IDLE, PACK, WRITE, DONE.
  - IDLE: capture=1 latches pe_out, PRECISION and base_addr, sets elem=0, slot=0, clears the word register, and moves to PACK next cycle.
  - PACK: one element per cycle goes into the current slot; elem increments.
    - If slot==E-1 or elem==NUM_PE-1: move to WRITE.
    - Otherwise: slot increments and the state stays in PACK.
  - WRITE: mem_req=1. mem_addr and mem_wdata are registered and held stable until the grant.
    - On grant: address increments, the word register clears and slot goes to 0.
    - Next state is DONE if the last element was packed, otherwise PACK.
    - mem_req drops in the cycle after the grant.
  - DONE: done=1 for one cycle, then IDLE.
- Latency with mem_gnt tied to 1:
  - The capture cycle is cycle 0.
  - The first mem_req is at cycle min(E,NUM_PE)+1.
  - done = NUM_PE + words + 1 cycles after capture.
- Capture:
  - Accepted only in IDLE.
  - Capture in PACK, WRITE or DONE is ignored and sets overrun. The snapshot in flight is unaffected.
  - If clear_overrun and an overrun-causing capture occur in the same cycle, set wins.
- pe_out is don't-care outside the capture cycle.

Optional Feature:
- Macro: PACKER_BYTE_MASK_EN.
- Defined:
  - Adds output port mem_be[3:0], valid while mem_req=1.
  - A full word gives mem_be=4'b1111.
  - A final partial word sets mem_be bit b only if byte b contains at least one valid element.
- Undefined: no mem_be port; partial words are written in full, with zero padding.

Test Plan:
- 8-bit pack:
  - Stimulus: NUM_PE=8, PRECISION=0, pe_out elements 0x01..0x08, base_addr=0x010, gnt=1, capture at cycle 0.
  - Response: write 0x04030201 to 0x010 at cycle 5, write 0x08070605 to 0x011 at cycle 10, done at cycle 11.
- 4-bit pack with negative element:
  - Stimulus: PRECISION=1, elements 1..7 and 0xFFFFFFF8 for PE7.
  - Response: single write 0x87654321 to base; done at cycle 10.
- 2-bit partial word:
  - Stimulus: PRECISION=2, elements 3,2,1,0,3,2,1,0.
  - Response: single write 0x00001B1B; with PACKER_BYTE_MASK_EN, mem_be=4'b0011.
- Grant stall:
  - Stimulus: mem_gnt=0 for 5 cycles during the first WRITE.
  - Response: mem_req, mem_addr and mem_wdata held constant; one write only; done delayed by 5 cycles.
- Overrun:
  - Stimulus: capture again during PACK.
  - Response: overrun=1, output data identical to the single-capture run; clear_overrun then gives overrun=0 next cycle.
- Reset mid-operation:
  - Stimulus: assert reset while mem_req=1.
  - Response: mem_req, busy and done are 0 immediately; after release, a new capture at base_addr=0x020 writes from 0x020.
